irq_sequencer: RTL and testbench

- Interrupt front-end and exception-entry sequencer for the single-cycle MIPS core.
- Synchronises the external interrupt lines plus the CP2-ready line, and latches rising edges as sticky pending bits.
- Applies a software-written mask and selects the highest-priority request.
- Runs a request/take/return handshake with the core's next-PC logic, capturing the EPC and owning the EXL bit that blocks nesting.

---
 rtl/irq_sequencer_if.sv | 33 +++
 rtl/irq_sequencer.sv | 122 ++++++++++++
 tb/tb_irq_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_sequencer_if.sv
// Core-side handshake between the interrupt sequencer and the next-PC / CP0 logic.
// master = sequencer (raises requests, owns EPC/EXL); slave = core (takes and returns).
interface irq_sequencer_if #(
    parameter int ID_W = 3
);
    logic [31:0]     pc_current;
    logic            take;
    logic            eret;
    logic            irq_req;
    logic [ID_W-1:0] irq_id;
    logic [31:0]     epc;
    logic            exl;

    modport master (
        input  pc_current,
        input  take,
        input  eret,
        output irq_req,
        output irq_id,
        output epc,
        output exl
    );

    modport slave (
        output pc_current,
        output take,
        output eret,
        input  irq_req,
        input  irq_id,
        input  epc,
        input  exl
    );
endinterface

// File: rtl/irq_sequencer.sv
// Interrupt front-end and exception-entry sequencer: synchronises lines, keeps sticky
// pending bits, masks and prioritises them, and runs the request/take/eret handshake.
module irq_sequencer #(
    parameter int NIRQ = 6,
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            we_mask,
    input  logic [NIRQ-1:0] mask_wd,
    input  logic [NIRQ-1:0] clr_pend,
    output logic [NIRQ-1:0] pending,
    output logic [NIRQ-1:0] mask,
    irq_sequencer_if.master core
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          state_q, state_next;

    logic [NIRQ-1:0] s1_q, s2_q, prev_q;
    logic [NIRQ-1:0] pending_q, mask_q;
    logic [NIRQ-1:0] rise, eligible, ack;

    logic [ID_W-1:0] irq_id_q, irq_id_next, top_id;
    logic [31:0]     epc_q, epc_next;
    logic            exl_q, exl_next;
    logic            irq_req_q;

    assign rise     = s2_q & ~prev_q;
    assign eligible = pending_q & mask_q;

    // Highest index wins: later iterations overwrite earlier matches.
    always_comb begin
        top_id = '0;
        for (int k = 0; k < NIRQ; k++) begin
            if (eligible[k]) top_id = ID_W'(k);
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_next  = state_q;
        irq_id_next = irq_id_q;
        epc_next    = epc_q;
        exl_next    = exl_q;
        ack         = '0;

        case (state_q)
            IDLE: begin
                if (!exl_q && (eligible != '0)) begin
                    state_next  = REQ;
                    irq_id_next = top_id;
                end
            end

            // Committed: mask/clear changes cannot withdraw or retarget the request.
            REQ: begin
                if (core.take) begin
                    state_next = SERVICE;
                    epc_next   = core.pc_current;
                    exl_next   = 1'b1;
                    for (int k = 0; k < NIRQ; k++) begin
                        ack[k] = (irq_id_q == ID_W'(k));
                    end
                end
            end

            SERVICE: begin
                if (core.eret) begin
                    state_next = IDLE;
                    exl_next   = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            state_q   <= IDLE;
            irq_id_q  <= '0;
            epc_q     <= '0;
            exl_q     <= 1'b0;
            irq_req_q <= 1'b0;
        end else begin
            s1_q      <= irq_in;
            s2_q      <= s1_q;
            prev_q    <= s2_q;
            // A fresh edge beats a same-cycle clear or ack.
            pending_q <= (pending_q & ~clr_pend & ~ack) | rise;
            if (we_mask) mask_q <= mask_wd;
            state_q   <= state_next;
            irq_id_q  <= irq_id_next;
            epc_q     <= epc_next;
            exl_q     <= exl_next;
            irq_req_q <= (state_next == REQ);
        end
    end

    assign pending      = pending_q;
    assign mask         = mask_q;
    assign core.irq_req = irq_req_q;
    assign core.irq_id  = irq_id_q;
    assign core.epc     = epc_q;
    assign core.exl     = exl_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: one task per scenario with hand-computed expectations.
module tb_irq_sequencer;

    logic       clk;
    logic       rst;
    logic [5:0] irq_in;
    logic       we_mask;
    logic [5:0] mask_wd;
    logic [5:0] clr_pend;
    logic [5:0] pending;
    logic [5:0] mask;

    int n_checks;
    int n_pass;

    irq_sequencer_if #(.ID_W(3)) core_if ();

    irq_sequencer #(.NIRQ(6), .ID_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .we_mask  (we_mask),
        .mask_wd  (mask_wd),
        .clr_pend (clr_pend),
        .pending  (pending),
        .mask     (mask),
        .core     (core_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        irq_in             = '0;
        we_mask            = 1'b0;
        mask_wd            = '0;
        clr_pend           = '0;
        core_if.take       = 1'b0;
        core_if.eret       = 1'b0;
        core_if.pc_current = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic write_mask(input logic [5:0] m);
        we_mask = 1'b1;
        mask_wd = m;
        step(1);
        we_mask = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        irq_in = 6'h3F;
        rst    = 1'b1;
        step(2);
        n_checks++; if (core_if.irq_req !== 1'b0) $display("FAIL reset_irq_req: got %0h expected 0", core_if.irq_req); else n_pass++;
        n_checks++; if (core_if.exl !== 1'b0) $display("FAIL reset_exl: got %0h expected 0", core_if.exl); else n_pass++;
        n_checks++; if (pending !== 6'h00) $display("FAIL reset_pending: got %0h expected 00", pending); else n_pass++;
        n_checks++; if (mask !== 6'h00) $display("FAIL reset_mask: got %0h expected 00", mask); else n_pass++;
        n_checks++; if (core_if.epc !== 32'h0) $display("FAIL reset_epc: got %0h expected 0", core_if.epc); else n_pass++;
        n_checks++; if (core_if.irq_id !== 3'd0) $display("FAIL reset_irq_id: got %0d expected 0", core_if.irq_id); else n_pass++;
        rst = 1'b0;
        step(2);
        n_checks++; if (pending !== 6'h00) $display("FAIL sync_latency_e1: got %0h expected 00", pending); else n_pass++;
        step(1);
        n_checks++; if (pending !== 6'h3F) $display("FAIL sync_latency_e2: got %0h expected 3f", pending); else n_pass++;
        step(2);
        n_checks++; if (core_if.irq_req !== 1'b0) $display("FAIL masked_no_req: got %0h expected 0", core_if.irq_req); else n_pass++;
        core_if.take       = 1'b1;
        core_if.pc_current = 32'hDEAD_BEEF;
        step(1);
        core_if.take = 1'b0;
        n_checks++; if (core_if.exl !== 1'b0) $display("FAIL take_in_idle_exl: got %0h expected 0", core_if.exl); else n_pass++;
        n_checks++; if (core_if.epc !== 32'h0) $display("FAIL take_in_idle_epc: got %0h expected 0", core_if.epc); else n_pass++;
    endtask

    task automatic test_single_request();
        do_reset();
        write_mask(6'h3F);
        n_checks++; if (mask !== 6'h3F) $display("FAIL mask_write: got %0h expected 3f", mask); else n_pass++;
        irq_in[3] = 1'b1;
        step(3);
        n_checks++; if (core_if.irq_req !== 1'b0) $display("FAIL single_req_at_e2: got %0h expected 0", core_if.irq_req); else n_pass++;
        step(1);
        n_checks++; if (core_if.irq_req !== 1'b1) $display("FAIL single_req_at_e3: got %0h expected 1", core_if.irq_req); else n_pass++;
        n_checks++; if (core_if.irq_id !== 3'd3) $display("FAIL single_irq_id: got %0d expected 3", core_if.irq_id); else n_pass++;
        irq_in = '0;
        core_if.eret = 1'b1;
        step(1);
        core_if.eret = 1'b0;
        n_checks++; if (core_if.exl !== 1'b0) $display("FAIL eret_in_req_exl: got %0h expected 0", core_if.exl); else n_pass++;
        step(4);
        n_checks++; if (core_if.irq_req !== 1'b1) $display("FAIL single_req_held: got %0h expected 1", core_if.irq_req); else n_pass++;
        n_checks++; if (core_if.irq_id !== 3'd3) $display("FAIL single_id_held: got %0d expected 3", core_if.irq_id); else n_pass++;
        core_if.take       = 1'b1;
        core_if.pc_current = 32'h0000_0040;
        step(1);
        core_if.take = 1'b0;
        n_checks++; if (core_if.epc !== 32'h40) $display("FAIL single_epc: got %0h expected 40", core_if.epc); else n_pass++;
        n_checks++; if (core_if.exl !== 1'b1) $display("FAIL single_exl: got %0h expected 1", core_if.exl); else n_pass++;
        n_checks++; if (pending !== 6'h00) $display("FAIL single_ack_pending: got %0h expected 00", pending); else n_pass++;
        n_checks++; if (core_if.irq_req !== 1'b0) $display("FAIL single_req_drop: got %0h expected 0", core_if.irq_req); else n_pass++;
        core_if.eret = 1'b1;
        step(1);
        core_if.eret = 1'b0;
        n_checks++; if (core_if.exl !== 1'b0) $display("FAIL single_eret_exl: got %0h expected 0", core_if.exl); else n_pass++;
    endtask

    task automatic test_priority_nesting();
        do_reset();
        write_mask(6'h3F);
        irq_in = 6'h22;
        step(3);
        irq_in = '0;
        n_checks++; if (pending !== 6'h22) $display("FAIL prio_pending: got %0h expected 22", pending); else n_pass++;
        step(1);
        n_checks++; if (core_if.irq_id !== 3'd5) $display("FAIL prio_irq_id: got %0d expected 5", core_if.irq_id); else n_pass++;
        core_if.take       = 1'b1;
        core_if.pc_current = 32'h0000_0100;
        step(1);
        core_if.take = 1'b0;
        n_checks++; if (pending !== 6'h02) $display("FAIL prio_pending_after_take: got %0h expected 02", pending); else n_pass++;
        step(3);
        n_checks++; if (core_if.irq_req !== 1'b0) $display("FAIL nest_blocked: got %0h expected 0", core_if.irq_req); else n_pass++;
        n_checks++; if (core_if.exl !== 1'b1) $display("FAIL nest_exl: got %0h expected 1", core_if.exl); else n_pass++;
        core_if.eret = 1'b1;
        step(1);
        core_if.eret = 1'b0;
        n_checks++; if (core_if.irq_req !== 1'b0) $display("FAIL eret_gap: got %0h expected 0", core_if.irq_req); else n_pass++;
        step(1);
        n_checks++; if (core_if.irq_req !== 1'b1) $display("FAIL after_eret_req: got %0h expected 1", core_if.irq_req); else n_pass++;
        n_checks++; if (core_if.irq_id !== 3'd1) $display("FAIL after_eret_id: got %0d expected 1", core_if.irq_id); else n_pass++;
        core_if.take       = 1'b1;
        core_if.eret       = 1'b1;
        core_if.pc_current = 32'h0000_0200;
        step(1);
        core_if.take = 1'b0;
        core_if.eret = 1'b0;
        n_checks++; if (core_if.exl !== 1'b1) $display("FAIL take_eret_exl: got %0h expected 1", core_if.exl); else n_pass++;
        n_checks++; if (core_if.epc !== 32'h200) $display("FAIL take_eret_epc: got %0h expected 200", core_if.epc); else n_pass++;
        n_checks++; if (pending !== 6'h00) $display("FAIL take_eret_pending: got %0h expected 00", pending); else n_pass++;
    endtask

    task automatic test_mask_clear();
        do_reset();
        irq_in[2] = 1'b1;
        step(3);
        irq_in = '0;
        step(2);
        n_checks++; if (pending !== 6'h04) $display("FAIL masked_pending: got %0h expected 04", pending); else n_pass++;
        n_checks++; if (core_if.irq_req !== 1'b0) $display("FAIL masked_line_no_req: got %0h expected 0", core_if.irq_req); else n_pass++;
        write_mask(6'h04);
        n_checks++; if (core_if.irq_req !== 1'b0) $display("FAIL unmask_same_edge: got %0h expected 0", core_if.irq_req); else n_pass++;
        step(1);
        n_checks++; if (core_if.irq_req !== 1'b1) $display("FAIL unmask_req: got %0h expected 1", core_if.irq_req); else n_pass++;
        n_checks++; if (core_if.irq_id !== 3'd2) $display("FAIL unmask_id: got %0d expected 2", core_if.irq_id); else n_pass++;
        core_if.take = 1'b1;
        step(1);
        core_if.take = 1'b0;
        core_if.eret = 1'b1;
        step(1);
        core_if.eret = 1'b0;
        write_mask(6'h00);
        irq_in[2] = 1'b1;
        step(3);
        irq_in = '0;
        step(3);
        irq_in[2] = 1'b1;
        step(2);
        clr_pend = 6'h04;
        step(1);
        clr_pend = '0;
        n_checks++; if (pending !== 6'h04) $display("FAIL set_beats_clear: got %0h expected 04", pending); else n_pass++;
        clr_pend = 6'h04;
        step(1);
        clr_pend = '0;
        n_checks++; if (pending !== 6'h00) $display("FAIL sw_clear: got %0h expected 00", pending); else n_pass++;
        step(2);
        n_checks++; if (pending !== 6'h00) $display("FAIL level_one_edge: got %0h expected 00", pending); else n_pass++;
        irq_in = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_mask(6'h3F);
        irq_in[4] = 1'b1;
        step(4);
        irq_in = '0;
        n_checks++; if (core_if.irq_req !== 1'b1) $display("FAIL mid_pre_req: got %0h expected 1", core_if.irq_req); else n_pass++;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_checks++; if (core_if.irq_req !== 1'b0) $display("FAIL rst_in_req_req: got %0h expected 0", core_if.irq_req); else n_pass++;
        n_checks++; if (pending !== 6'h00) $display("FAIL rst_in_req_pending: got %0h expected 00", pending); else n_pass++;
        step(1);
        n_checks++; if (core_if.irq_req !== 1'b0) $display("FAIL rst_in_req_idle: got %0h expected 0", core_if.irq_req); else n_pass++;
        write_mask(6'h3F);
        irq_in[4] = 1'b1;
        step(4);
        irq_in = '0;
        core_if.take       = 1'b1;
        core_if.pc_current = 32'h0000_0080;
        step(1);
        core_if.take = 1'b0;
        n_checks++; if (core_if.epc !== 32'h80) $display("FAIL mid_service_epc: got %0h expected 80", core_if.epc); else n_pass++;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_checks++; if (core_if.exl !== 1'b0) $display("FAIL rst_in_service_exl: got %0h expected 0", core_if.exl); else n_pass++;
        n_checks++; if (core_if.epc !== 32'h0) $display("FAIL rst_in_service_epc: got %0h expected 0", core_if.epc); else n_pass++;
        n_checks++; if (core_if.irq_req !== 1'b0) $display("FAIL rst_in_service_req: got %0h expected 0", core_if.irq_req); else n_pass++;
        write_mask(6'h3F);
        irq_in[0] = 1'b1;
        step(4);
        irq_in = '0;
        n_checks++; if (core_if.irq_req !== 1'b1) $display("FAIL rst_back_to_idle_req: got %0h expected 1", core_if.irq_req); else n_pass++;
        n_checks++; if (core_if.irq_id !== 3'd0) $display("FAIL rst_back_to_idle_id: got %0d expected 0", core_if.irq_id); else n_pass++;
    endtask

    task automatic test_committed();
        do_reset();
        write_mask(6'h3F);
        irq_in[3] = 1'b1;
        step(4);
        irq_in   = '0;
        we_mask  = 1'b1;
        mask_wd  = 6'h00;
        clr_pend = 6'h08;
        step(1);
        we_mask  = 1'b0;
        clr_pend = '0;
        n_checks++; if (mask !== 6'h00) $display("FAIL commit_mask: got %0h expected 00", mask); else n_pass++;
        n_checks++; if (pending !== 6'h00) $display("FAIL commit_pending: got %0h expected 00", pending); else n_pass++;
        step(2);
        n_checks++; if (core_if.irq_req !== 1'b1) $display("FAIL commit_req_held: got %0h expected 1", core_if.irq_req); else n_pass++;
        n_checks++; if (core_if.irq_id !== 3'd3) $display("FAIL commit_id_held: got %0d expected 3", core_if.irq_id); else n_pass++;
        core_if.take       = 1'b1;
        core_if.pc_current = 32'h0000_00C0;
        step(1);
        core_if.take = 1'b0;
        n_checks++; if (core_if.irq_req !== 1'b0) $display("FAIL commit_take_req: got %0h expected 0", core_if.irq_req); else n_pass++;
        n_checks++; if (core_if.epc !== 32'hC0) $display("FAIL commit_take_epc: got %0h expected c0", core_if.epc); else n_pass++;
        n_checks++; if (core_if.exl !== 1'b1) $display("FAIL commit_take_exl: got %0h expected 1", core_if.exl); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        clear_inputs();
        test_reset();
        test_single_request();
        test_priority_nesting();
        test_mask_clear();
        test_reset_mid();
        test_committed();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
